mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-client memory arbiter directly downstream of the instruction cache and the data cache; one side is the single shared memory port.
- Serialises block transactions: one outstanding at a time, round-robin on contention.
- Holds granted request stable toward memory; returns read data and a ready pulse to the granted client only.
- Handles the caches' one-cycle-late request release (caches register mem_ready, so their request stays high one cycle after completion).

Parameters:
ADDR_W, 28, block address width
DATA_W, 128, block data width

Ports:
clk  input  1  system clock, all logic on rising edge
proc_reset  input  1  asynchronous, active-high reset
i_mem_read  input  1  I-cache read request
i_mem_write  input  1  I-cache write request (normally tied 0, still arbitrated)
i_mem_addr  input  ADDR_W  I-cache block address
i_mem_wdata  input  DATA_W  I-cache write data
i_mem_rdata  output  DATA_W  read data to I-cache
i_mem_ready  output  1  completion pulse to I-cache
d_mem_read  input  1  D-cache read request
d_mem_write  input  1  D-cache write request
d_mem_addr  input  ADDR_W  D-cache block address
d_mem_wdata  input  DATA_W  D-cache write data
d_mem_rdata  output  DATA_W  read data to D-cache
d_mem_ready  output  1  completion pulse to D-cache
mem_read  output  1  read strobe to memory
mem_write  output  1  write strobe to memory
mem_addr  output  ADDR_W  address to memory
mem_wdata  output  DATA_W  write data to memory
mem_rdata  input  DATA_W  memory read data, valid with mem_ready
mem_ready  input  1  memory completion, one cycle

Behaviour:
- Reset (async, active-high, immediate): state IDLE, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, both rdata capture registers 0, last_grant=I.
- Reset also applies mid-transaction: the transaction is abandoned and no ready pulse is issued.
- Client request = read|write. States: IDLE, GNT_I, GNT_D, RETIRE.
- IDLE:
  - Only one client requesting: grant it.
  - Both requesting: grant the one not equal to last_grant, so after reset D wins the first tie.
  - No request: stay in IDLE.
  - Granting: next state GNT_x; register the client's read/write/addr/wdata into the memory output registers.
  - If the client asserts write and read together, mem_write=1 and mem_read=0.
- Latency: request seen in cycle t -> memory strobe high in cycle t+1.
- GNT_x:
  - Memory outputs held constant. Client input changes are ignored until completion.
  - mem_ready=1: x_mem_ready=1 in the same cycle (combinational, granted client only).
  - On that same mem_ready cycle: x_mem_rdata = mem_rdata (pass-through); capture register loaded with mem_rdata.
  - Next cycle: mem_read=mem_write=0, last_grant=x, state RETIRE.
- RETIRE (exactly 1 cycle):
  - The just-served client's request is masked, since it is still high because of its buffered ready.
  - If the other client requests: grant it directly (next state GNT_other, outputs registered as in IDLE). Otherwise go to IDLE.
- x_mem_rdata outside the pass-through cycle = that client's capture register. It stays stable until that client's next completion, so a cache consuming data one cycle after ready sees correct data.
- Non-granted client: ready=0 always, rdata held.
- mem_ready in IDLE or RETIRE: ignored; no ready pulse; no capture.
- No back-to-back grant to the same client without an intervening RETIRE.
- Max wait for a requester: one full transaction of the other client plus 2 cycles.

Test Plan:
- Reset mid-GNT_D with mem_read=1 -> mem_read=0 immediately (no clock edge); no d_mem_ready ever pulses for that transaction; state IDLE.
- I-only read addr 0x0000012, memory ready after 5 cycles with rdata 0xA5..A5 -> mem_read high 1 cycle after request, mem_addr=0x0000012 throughout. i_mem_ready pulses with mem_ready. i_mem_rdata=0xA5..A5 that cycle and the next. No second memory read while i_mem_read stays high 1 cycle after.
- I and D request in same cycle after reset -> D granted first. I granted in D's RETIRE cycle, so I's mem_read rises 2 cycles after D's mem_ready.
- D write addr 0x10 data 0x1234 while I reads -> mem_write=1, mem_read=0, mem_wdata=0x1234 during GNT_D. i_mem_ready stays 0 until I's own completion.
- Back-to-back I reads with D idle -> RETIRE cycle between them; mem_read low exactly 2 cycles between transactions.
- Spurious mem_ready in IDLE -> no ready pulse on either client; both rdata registers unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of a single block-memory port.
// One transaction at a time, round-robin on ties, one RETIRE cycle after each completion.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,

    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_I  = 2'd1,
        GNT_D  = 2'd2,
        RETIRE = 2'd3
    } state_t;

    typedef enum logic {
        CLI_I = 1'b0,
        CLI_D = 1'b1
    } client_t;

    state_t            state;
    state_t            next_state;
    client_t           last_grant;
    client_t           grant_sel;
    logic              grant_load;

    logic              i_req;
    logic              d_req;
    logic              i_done;
    logic              d_done;

    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] i_cap;
    logic [DATA_W-1:0] d_cap;

    assign i_req = i_mem_read | i_mem_write;
    assign d_req = d_mem_read | d_mem_write;

    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: defaults up front so no path leaves a comb output unassigned (no latch).
        next_state = state;
        grant_load = 1'b0;
        grant_sel  = CLI_I;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    grant_load = 1'b1;
                    if (last_grant == CLI_I) begin
                        grant_sel = CLI_D;
                    end else begin
                        grant_sel = CLI_I;
                    end
                end else if (i_req) begin
                    grant_load = 1'b1;
                    grant_sel  = CLI_I;
                end else if (d_req) begin
                    grant_load = 1'b1;
                    grant_sel  = CLI_D;
                end
            end
            GNT_I: begin
                if (mem_ready) begin
                    next_state = RETIRE;
                end
            end
            GNT_D: begin
                if (mem_ready) begin
                    next_state = RETIRE;
                end
            end
            RETIRE: begin
                // The client just served still shows its request for one cycle; only the other may win.
                next_state = IDLE;
                if (last_grant == CLI_I && d_req) begin
                    grant_load = 1'b1;
                    grant_sel  = CLI_D;
                end else if (last_grant == CLI_D && i_req) begin
                    grant_load = 1'b1;
                    grant_sel  = CLI_I;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (grant_load) begin
            if (grant_sel == CLI_I) begin
                next_state = GNT_I;
            end else begin
                next_state = GNT_D;
            end
        end
    end

    always_comb begin
        i_done      = (state == GNT_I) && mem_ready;
        d_done      = (state == GNT_D) && mem_ready;
        i_mem_ready = i_done;
        d_mem_ready = d_done;
        i_mem_rdata = i_done ? mem_rdata : i_cap;
        d_mem_rdata = d_done ? mem_rdata : d_cap;
    end

    always_comb begin
        if (grant_sel == CLI_D) begin
            sel_read  = d_mem_read;
            sel_write = d_mem_write;
            sel_addr  = d_mem_addr;
            sel_wdata = d_mem_wdata;
        end else begin
            sel_read  = i_mem_read;
            sel_write = i_mem_write;
            sel_addr  = i_mem_addr;
            sel_wdata = i_mem_wdata;
        end
    end

    // Grant and completion are mutually exclusive: grants only leave IDLE/RETIRE.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_cap       <= '0;
            d_cap       <= '0;
            last_grant  <= CLI_I;
        end else begin
            if (grant_load) begin
                mem_write_q <= sel_write;
                mem_read_q  <= sel_read & ~sel_write;
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
            end else if (i_done || d_done) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
            end
            if (i_done) begin
                i_cap      <= mem_rdata;
                last_grant <= CLI_I;
            end
            if (d_done) begin
                d_cap      <= mem_rdata;
                last_grant <= CLI_D;
            end
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
